memory_stage: RTL

// EX/MEM pipeline register, data-memory access controller and MEM/WB pipeline register in one block.

---
 rtl/memory_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// EX/MEM register, req/ack data-memory access controller and MEM/WB register.
// A memory op occupies M until the bus acks; a timeout or misaligned address locks the stage in ERR.
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        MemtoRegE,
    input  logic        PCSrcE,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        StallM,
    output logic        MemErr,
    output logic [31:0] ALUResultM,
    output logic [3:0]  WA3M,
    output logic        RegWriteM,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic [3:0]  WA3W,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          stall_s, done_s, req_s;

    logic [31:0]   alu_m_r, wdata_m_r;
    logic [3:0]    wa3_m_r;
    logic          regwrite_m_r, memwrite_m_r, memtoreg_m_r, pcsrc_m_r;

    logic [31:0]   aluout_w_r, readdata_w_r;
    logic [3:0]    wa3_w_r;
    logic          regwrite_w_r, memtoreg_w_r, pcsrc_w_r;

    // Where an instruction lands in the FSM on the edge it is captured into M.
    function automatic state_t capture_state(input logic memop, input logic [1:0] addr_lo);
        state_t st;
        if (!memop) begin
            st = IDLE;
        end else if (addr_lo != 2'b00) begin
            st = ERR;
        end else begin
            st = REQ;
        end
        return st;
    endfunction

    // Next-state, wait counter and M-stage completion/stall decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        done_s      = 1'b0;
        req_s       = 1'b0;
        case (state_r)
            IDLE: begin
                done_s      = 1'b1;
                cnt_nxt_s   = '0;
                state_nxt_s = capture_state(MemWriteE | MemtoRegE, ALUResultE[1:0]);
            end
            REQ: begin
                req_s = 1'b1;
                if (MemAck) begin
                    done_s      = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = capture_state(MemWriteE | MemtoRegE, ALUResultE[1:0]);
                end else begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                    // cnt_r counts prior unacked cycles, so the request lives TIMEOUT+1 cycles
                    if ((TIMEOUT != 32'd0) && (cnt_r == CW'(TIMEOUT))) begin
                        state_nxt_s = ERR;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
            end
            ERR: begin
                stall_s = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // EX/MEM register: frozen while M is stalled.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            alu_m_r      <= 32'h0;
            wdata_m_r    <= 32'h0;
            wa3_m_r      <= 4'h0;
            regwrite_m_r <= 1'b0;
            memwrite_m_r <= 1'b0;
            memtoreg_m_r <= 1'b0;
            pcsrc_m_r    <= 1'b0;
        end else if (!stall_s) begin
            alu_m_r      <= ALUResultE;
            wdata_m_r    <= WriteDataE;
            wa3_m_r      <= WA3E;
            regwrite_m_r <= RegWriteE;
            memwrite_m_r <= MemWriteE;
            memtoreg_m_r <= MemtoRegE;
            pcsrc_m_r    <= PCSrcE;
        end
    end

    // MEM/WB register: completing ops load W, stalled cycles insert bubbles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            aluout_w_r   <= 32'h0;
            readdata_w_r <= 32'h0;
            wa3_w_r      <= 4'h0;
            regwrite_w_r <= 1'b0;
            memtoreg_w_r <= 1'b0;
            pcsrc_w_r    <= 1'b0;
        end else if (done_s) begin
            aluout_w_r   <= alu_m_r;
            wa3_w_r      <= wa3_m_r;
            regwrite_w_r <= regwrite_m_r;
            memtoreg_w_r <= memtoreg_m_r;
            pcsrc_w_r    <= pcsrc_m_r;
            if (memtoreg_m_r) begin
                readdata_w_r <= MemRData;
            end
        end else begin
            regwrite_w_r <= 1'b0;
            memtoreg_w_r <= 1'b0;
            pcsrc_w_r    <= 1'b0;
        end
    end

    assign MemReq     = req_s;
    assign MemWe      = req_s & memwrite_m_r;
    assign MemAddr    = req_s ? alu_m_r : 32'h0;
    assign MemWData   = req_s ? wdata_m_r : 32'h0;
    assign StallM     = stall_s;
    assign MemErr     = (state_r == ERR);
    assign ALUResultM = alu_m_r;
    assign WA3M       = wa3_m_r;
    assign RegWriteM  = regwrite_m_r;
    assign ALUOutW    = aluout_w_r;
    assign ReadDataW  = readdata_w_r;
    assign WA3W       = wa3_w_r;
    assign RegWriteW  = regwrite_w_r;
    assign MemtoRegW  = memtoreg_w_r;
    assign PCSrcW     = pcsrc_w_r;

endmodule
